// File: rtl/freq_gen_pkg.sv
// Shared types and widths for the frequency-select path and the tone generator.
package freq_gen_pkg;

  localparam int FW_W      = 7;
  localparam int OCT_W     = 3;
  localparam int ACC_W_MIN = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/freq_phase_gen_phase_acc.sv
// Phase accumulator: an ACC_W+1 bit add whose carry-out marks the end of a period.
module phase_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             clr,
  input  logic [ACC_W-1:0] inc,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [ACC_W:0] sum;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = step_en & sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (step_en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/freq_phase_gen.sv
// Tone generator: new frequency settings take effect only at a period boundary,
// or immediately when the active increment is zero.
module freq_phase_gen
  import freq_gen_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int PH_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [FW_W-1:0]  fw,
  input  logic [OCT_W-1:0] freq_control,
  output logic             sq_out,
  output logic [PH_W-1:0]  phase,
  output logic             wrap,
  output logic             upd_pending,
  output logic             running
);

  if (ACC_W < ACC_W_MIN || ACC_W > 32) begin : g_bad_acc_w
    $error("freq_phase_gen: ACC_W out of range");
  end
  if (PH_W > ACC_W) begin : g_bad_ph_w
    $error("freq_phase_gen: PH_W wider than ACC_W");
  end

  fsm_state_t       state;
  logic [ACC_W-1:0] fw_ext;
  logic [ACC_W-1:0] shadow_inc;
  logic [ACC_W-1:0] act_inc;
  logic [ACC_W-1:0] acc;
  logic             carry;
  logic             step_en;
  logic             clr;
  logic             load_act;
  logic             act_zero;

  assign fw_ext   = ACC_W'(fw);
  assign act_zero = (act_inc == '0);
  assign step_en  = (state == RUN) || (state == STOP);
  // A stopped tone finishes its period, then parks with the phase cleared.
  assign clr      = (state == IDLE) ||
                    ((state == STOP) && !en && (carry || act_zero));
  assign load_act = (state == IDLE) || act_zero || carry;

  phase_acc #(
    .ACC_W(ACC_W)
  ) u_phase_acc (
    .clk    (clk),
    .rst    (rst),
    .step_en(step_en),
    .clr    (clr),
    .inc    (act_inc),
    .acc    (acc),
    .carry  (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow_inc <= '0;
      act_inc    <= '0;
      wrap       <= 1'b0;
      running    <= 1'b0;
    end else begin
      shadow_inc <= fw_ext << freq_control;
      wrap       <= carry;
      if (load_act) begin
        act_inc <= shadow_inc;
      end
      case (state)
        IDLE: begin
          if (en) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (en) begin
            state <= RUN;
          end else if (carry || act_zero) begin
            state   <= IDLE;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign sq_out      = acc[ACC_W-1];
  assign phase       = acc[ACC_W-1 -: PH_W];
  assign upd_pending = (shadow_inc != act_inc);

endmodule
